// File: rtl/shift_right_iter.sv
// shift_right_iter: multi-cycle 64-bit right shifter (SRL/SRA, ROR when SHIFT_ROTATE_EN is defined)
module shift_right_iter #(
  parameter int WIDTH = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         op,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, step;
  logic [SHAMT_W-1:0] amt;
  logic [1:0] op_q;
  logic sign_q;
  logic [2:0] stg;
  logic [2*WIDTH-1:0] ext, sh;
  // the upper half of ext supplies the fill bits that slide into the vacated MSBs
  always_comb begin
`ifdef SHIFT_ROTATE_EN
    ext = (op_q == 2'b10) ? {acc, acc} :
          (op_q == 2'b01) ? {{WIDTH{sign_q}}, acc} : {{WIDTH{1'b0}}, acc};
`else
    ext = (op_q == 2'b01) ? {{WIDTH{sign_q}}, acc} : {{WIDTH{1'b0}}, acc};
`endif
    sh = ext >> (7'd1 << stg);
    step = amt[stg] ? sh[WIDTH-1:0] : acc;
  end
  always_comb begin
    state_n = (state == SHIFT) ? ((stg == 3'd5) ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      amt <= '0;
      op_q <= '0;
      sign_q <= 1'b0;
      stg <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (state != SHIFT && start) begin
        acc <= a;
        amt <= b;
        op_q <= op;
        sign_q <= a[WIDTH-1];
        stg <= '0;
      end else if (state == SHIFT) begin
        acc <= step;
        stg <= stg + 3'd1;
        if (stg == 3'd5) result <= step;
      end
    end
  end
  assign busy = (state == SHIFT);
  assign done = (state == DONE);
endmodule

// File: tb/tb_shift_right_iter.sv
// tb_shift_right_iter: directed self-checking bench for shift_right_iter
module tb_shift_right_iter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [63:0] a = '0;
  logic [5:0] b = '0;
  logic [1:0] op = '0;
  logic busy, done;
  logic [63:0] result;
  int passed = 0;
  int total = 0;

  shift_right_iter dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic go(input logic [63:0] ta, input logic [5:0] tb_, input logic [1:0] top);
    start = 1'b1;
    a = ta;
    b = tb_;
    op = top;
    @(negedge clk);
    start = 1'b0;
  endtask

  // entered in cycle c of the operation; leaves in cycle 7 after checking done/result
  task automatic finish_op(input string tag, input logic [63:0] exp, input int c);
    for (int i = c; i <= 6; i++) begin
      chk({tag, "_busy"}, {63'b0, busy}, 64'd1);
      chk({tag, "_nodone"}, {63'b0, done}, 64'd0);
      @(negedge clk);
    end
    chk({tag, "_done"}, {63'b0, done}, 64'd1);
    chk({tag, "_idlebusy"}, {63'b0, busy}, 64'd0);
    chk({tag, "_result"}, result, exp);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_result", result, 64'd0);
    go(64'hFFFF_FFFF_FFFF_FFFF, 6'd4, 2'b00);
    finish_op("srl4", 64'h0FFF_FFFF_FFFF_FFFF, 1);
    @(negedge clk);
    chk("done_pulse", {63'b0, done}, 64'd0);
    chk("result_held", result, 64'h0FFF_FFFF_FFFF_FFFF);

    go(64'h8000_0000_0000_0000, 6'd63, 2'b01);
    finish_op("sra63", 64'hFFFF_FFFF_FFFF_FFFF, 1);
    go(64'h8000_0000_0000_0000, 6'd63, 2'b00);
    finish_op("srl63", 64'h0000_0000_0000_0001, 1);
    go(64'h7000_0000_0000_0000, 6'd60, 2'b01);
    finish_op("sra_pos", 64'h0000_0000_0000_0007, 1);
    go(64'hF000_0000_0000_0000, 6'd4, 2'b11);
    finish_op("op11", 64'h0F00_0000_0000_0000, 1);
    @(negedge clk);

    go(64'h1234_5678_9ABC_DEF0, 6'd0, 2'b01);
    start = 1'b1;
    a = 64'hDEAD_BEEF_DEAD_BEEF;
    b = 6'd5;
    op = 2'b00;
    @(negedge clk);
    start = 1'b0;
    finish_op("zero_ignore", 64'h1234_5678_9ABC_DEF0, 2);
    @(negedge clk);
    go(64'hFFFF_0000_FFFF_0000, 6'd0, 2'b00);
    finish_op("zero_srl", 64'hFFFF_0000_FFFF_0000, 1);
    @(negedge clk);

    go(64'hFEDC_BA98_7654_3210, 6'd16, 2'b00);
    finish_op("b2b_a", 64'h0000_FEDC_BA98_7654, 1);
    go(64'h8000_0000_0000_0000, 6'd8, 2'b01);
    finish_op("b2b_b", 64'hFF80_0000_0000_0000, 1);
    @(negedge clk);

    go(64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_result", result, 64'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("abort_nodone", {63'b0, done}, 64'd0);
    end

`ifdef SHIFT_ROTATE_EN
    go(64'h0000_0000_0000_0001, 6'd1, 2'b10);
    finish_op("ror1", 64'h8000_0000_0000_0000, 1);
    go(64'h8000_0000_0000_0001, 6'd63, 2'b10);
    finish_op("ror63", 64'h0000_0000_0000_0003, 1);
`else
    go(64'h0000_0000_0000_0001, 6'd1, 2'b10);
    finish_op("ror1_off", 64'h0000_0000_0000_0000, 1);
    go(64'h8000_0000_0000_0001, 6'd63, 2'b10);
    finish_op("ror63_off", 64'h0000_0000_0000_0001, 1);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
